layer_seq: RTL and testbench
============================

LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 Parameter NL, default 4, is the number of layer descriptor entries (power of two, 2..8).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cfg_we  input  1  descriptor write strobe.
REQ-005 cfg_idx  input  log2(NL)  descriptor entry index.
REQ-006 cfg_d  input  43  descriptor {wcnt[42:33], dst_a_max[32:24], src_a_max[23:15], kernel[14:10], out_ch[9:5], sample[4:0]}.
REQ-007 num_layers  input  log2(NL)  number of layers to run minus 1; sampled on start.
REQ-008 start  input  1  single-cycle pulse that begins a sequence.
REQ-009 abort  input  1  synchronous abort of a sequence.
REQ-010 w_hs  input  1  weight beat accepted on stream input (TVALID&TREADY).
REQ-011 o_last_hs  input  1  final output beat accepted (TVALID&TREADY&TLAST).
REQ-012 matw, run, last  output  1 each  datapath mode controls.
REQ-013 sample, out_ch, kernel  output  5 each  active layer fields.
REQ-014 src_a_max, dst_a_max  output  9 each  active layer fields.
REQ-015 cur_layer  output  log2(NL)  index of the active layer.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at sequence completion.

Function
REQ-018 States: IDLE, LOAD, MATW, GAP, RUN, NEXT; state register, layer counter, beat counter and field registers are all clocked on clk.
REQ-019 Descriptor RAM: NL x 43 bits; written on cfg_we only in IDLE; cfg_we outside IDLE is ignored.
REQ-020 IDLE: start=1 latches num_layers, sets cur_layer=0, moves to LOAD next cycle; start outside IDLE is ignored.
REQ-021 LOAD (1 cycle): copies descriptor[cur_layer] fields to outputs, clears beat counter; goes to MATW if wcnt!=0, otherwise GAP.
REQ-022 MATW: matw=1; each w_hs increments the 10-bit beat counter; when w_hs arrives with counter==wcnt-1, matw drops on the next edge and the state moves to GAP.
REQ-023 GAP (2 cycles): matw=run=0, which holds the datapath sequencers in reset; then RUN.
REQ-024 RUN: run=1; last=1 only when cur_layer==latched num_layers; on o_last_hs go to NEXT, with run dropping on that edge.
REQ-025 NEXT (1 cycle): if cur_layer==num_layers, pulse done and go to IDLE; otherwise increment cur_layer and go to LOAD.
REQ-026 w_hs outside MATW and o_last_hs outside RUN are ignored; matw and run are never high together.
REQ-027 abort in any non-IDLE state forces IDLE on the next edge: matw=run=last=0, done not pulsed, field outputs hold their values. abort in IDLE has no effect. abort has priority over all other events in the same cycle.
REQ-028 If start and abort are both high in IDLE, abort wins and the block stays in IDLE.
REQ-029 Field outputs change only in LOAD and stay stable for the whole layer.

Reset
REQ-030 reset=1 asynchronously forces IDLE, clears matw/run/last/busy/done, clears cur_layer and all field outputs to 0, and clears the beat counter, including mid-sequence; descriptor RAM contents are not reset.

Verification
REQ-031 Load 1 descriptor {wcnt=3, out_ch=7, kernel=8, sample=9, src=15, dst=3}, num_layers=0, start -> matw high for exactly 3 w_hs; then 2-cycle GAP; then run=1 and last=1; o_last_hs -> done pulse, busy=0.
REQ-032 num_layers=2 with 3 distinct descriptors -> cur_layer steps 0,1,2; fields change only in LOAD; last=1 only during layer 2 RUN; exactly one done pulse.
REQ-033 Descriptor with wcnt=0 -> MATW skipped, matw never asserted, LOAD->GAP->RUN.
REQ-034 Assert abort during layer 1 MATW after 2 beats -> next cycle IDLE, matw=0, no done pulse; a new start reruns from layer 0.
REQ-035 Assert reset during RUN -> run/last/busy drop immediately without waiting for a clock edge; outputs are 0; descriptors are retained (restart gives the same fields).
REQ-036 Apply cfg_we and start while busy, w_hs during RUN, and o_last_hs during MATW -> descriptor unchanged and the sequence is unaffected.

Source files
------------

// File: rtl/layer_seq.sv
// Layer sequencer: steps through NL stored layer descriptors, loading weights (MATW),
// waiting two GAP cycles, then running each layer until its final output beat is accepted.
module layer_seq #(
  parameter int NL = 4,
  localparam int IW = $clog2(NL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [42:0]   cfg_d,
  input  logic [IW-1:0] num_layers,
  input  logic          start,
  input  logic          abort,
  input  logic          w_hs,
  input  logic          o_last_hs,
  output logic          matw,
  output logic          run,
  output logic          last,
  output logic [4:0]    sample,
  output logic [4:0]    out_ch,
  output logic [4:0]    kernel,
  output logic [8:0]    src_a_max,
  output logic [8:0]    dst_a_max,
  output logic [IW-1:0] cur_layer,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MATW = 3'd2,
    S_GAP  = 3'd3,
    S_RUN  = 3'd4,
    S_NEXT = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [42:0]   desc [NL];
  logic [42:0]   desc_rd;
  logic [IW-1:0] nl_lat;
  logic [9:0]    wcnt_r;
  logic [9:0]    beat;
  logic          gap_cnt;
  logic [32:0]   fields;
  logic          last_layer;

  // Descriptor storage is deliberately not reset so configuration survives a reset.
  always_ff @(posedge clk) begin
    if (cfg_we && state == S_IDLE) desc[cfg_idx] <= cfg_d;
  end

  assign desc_rd    = desc[cur_layer];
  assign last_layer = (cur_layer == nl_lat);

  // w_hs and o_last_hs are already-qualified beats (TVALID & TREADY [& TLAST]);
  // the sequencer only counts them and never back-pressures the streams.
  always_comb begin
    state_nxt = state;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start && !abort) state_nxt = S_LOAD;
        S_LOAD: state_nxt = (desc_rd[42:33] != 10'd0) ? S_MATW : S_GAP;
        S_MATW: if (w_hs && beat == wcnt_r - 10'd1) state_nxt = S_GAP;
        S_GAP:  if (gap_cnt) state_nxt = S_RUN;
        S_RUN:  if (o_last_hs) state_nxt = S_NEXT;
        S_NEXT: state_nxt = last_layer ? S_IDLE : S_LOAD;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_layer <= '0;
      nl_lat    <= '0;
      wcnt_r    <= '0;
      beat      <= '0;
      gap_cnt   <= 1'b0;
      fields    <= '0;
    end else begin
      state <= state_nxt;
      if (!abort) begin
        case (state)
          S_IDLE: if (start) begin
            nl_lat    <= num_layers;
            cur_layer <= '0;
          end
          S_LOAD: begin
            fields  <= desc_rd[32:0];
            wcnt_r  <= desc_rd[42:33];
            beat    <= '0;
            gap_cnt <= 1'b0;
          end
          S_MATW: if (w_hs) beat <= beat + 10'd1;
          S_GAP:  gap_cnt <= ~gap_cnt;
          S_NEXT: if (!last_layer) cur_layer <= cur_layer + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign matw      = (state == S_MATW);
  assign run       = (state == S_RUN);
  assign last      = run && last_layer;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_NEXT) && last_layer && !abort;
  assign state_dbg = state;

  assign dst_a_max = fields[32:24];
  assign src_a_max = fields[23:15];
  assign kernel    = fields[14:10];
  assign out_ch    = fields[9:5];
  assign sample    = fields[4:0];

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq: single/multi-layer runs, wcnt=0 skip, abort,
// mid-run reset and ignored inputs while busy.
module tb_layer_seq;
  localparam int NL = 4;
  localparam int IW = 2;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_MATW = 3'd2,
                         S_GAP = 3'd3, S_RUN = 3'd4, S_NEXT = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [42:0]   cfg_d;
  logic [IW-1:0] num_layers;
  logic          start, abort, w_hs, o_last_hs;
  logic          matw, run, last, busy, done;
  logic [4:0]    sample, out_ch, kernel;
  logic [8:0]    src_a_max, dst_a_max;
  logic [IW-1:0] cur_layer;
  logic [2:0]    state_dbg;
  logic [32:0]   fld;

  int checks = 0;
  int errors = 0;

  layer_seq #(.NL(NL)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_d(cfg_d),
    .num_layers(num_layers), .start(start), .abort(abort), .w_hs(w_hs),
    .o_last_hs(o_last_hs), .matw(matw), .run(run), .last(last), .sample(sample),
    .out_ch(out_ch), .kernel(kernel), .src_a_max(src_a_max), .dst_a_max(dst_a_max),
    .cur_layer(cur_layer), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign fld = {dst_a_max, src_a_max, kernel, out_ch, sample};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [42:0] mk(input int w, input int d, input int s,
                                     input int k, input int o, input int sm);
    return {w[9:0], d[8:0], s[8:0], k[4:0], o[4:0], sm[4:0]};
  endfunction

  task automatic write_desc(input int idx, input logic [42:0] d);
    cfg_we = 1'b1; cfg_idx = idx[IW-1:0]; cfg_d = d;
    step();
    cfg_we = 1'b0;
  endtask

  // Pulse start, then scramble num_layers to show the value was latched.
  task automatic start_seq(input int nl);
    num_layers = nl[IW-1:0]; start = 1'b1;
    step();
    start = 1'b0; num_layers = ~nl[IW-1:0];
  endtask

  // Entered on the negedge where the DUT is in LOAD for layer idx.
  task automatic run_layer(input int idx, input logic [42:0] d, input logic [42:0] prev,
                           input bit is_last, input bit junk, input bit rst_in_run);
    int w;
    logic [42:0] nd;
    w = int'(d[42:33]);
    nd = ~d;
    chk("load_state", state_dbg, S_LOAD);
    chk("load_idx", cur_layer, idx);
    chk("load_fields_hold", fld, prev[32:0]);
    if (junk) begin
      cfg_we = 1'b1; cfg_idx = idx[IW-1:0]; cfg_d = nd; start = 1'b1;
    end
    step();
    chk("fields", fld, d[32:0]);
    if (w == 0) begin
      chk("skip_matw", matw, 1'b0);
    end else begin
      chk("matw_on", matw, 1'b1);
      o_last_hs = junk;
      step();
      o_last_hs = 1'b0;
      chk("matw_wait", state_dbg, S_MATW);
      for (int b = 0; b < w; b++) begin
        chk("matw_beat", matw, 1'b1);
        chk("matw_run_off", run, 1'b0);
        w_hs = 1'b1; o_last_hs = junk;
        step();
        w_hs = 1'b0; o_last_hs = 1'b0;
      end
    end
    chk("gap1", state_dbg, S_GAP);
    chk("gap_ctl", {matw, run}, 2'b00);
    step();
    chk("gap2", state_dbg, S_GAP);
    step();
    chk("run_on", run, 1'b1);
    chk("run_last", last, is_last);
    chk("run_matw_off", matw, 1'b0);
    chk("run_fields", fld, d[32:0]);
    chk("run_idx", cur_layer, idx);
    if (rst_in_run) begin
      cfg_we = 1'b0; start = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_run", run, 1'b0);
      chk("rst_last", last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_matw", matw, 1'b0);
      chk("rst_layer", cur_layer, 0);
      chk("rst_fields", fld, 0);
      chk("rst_state", state_dbg, S_IDLE);
      reset = 1'b0;
      return;
    end
    w_hs = junk;
    step();
    w_hs = 1'b0;
    chk("run_hold", state_dbg, S_RUN);
    o_last_hs = 1'b1; cfg_we = 1'b0; start = 1'b0;
    step();
    o_last_hs = 1'b0;
    chk("next_state", state_dbg, S_NEXT);
    chk("next_run_off", run, 1'b0);
    chk("done", done, is_last);
    step();
    if (is_last) begin
      chk("end_busy", busy, 1'b0);
      chk("end_done_clr", done, 1'b0);
    end
  endtask

  logic [42:0] d0, da, db, dc;

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_d = '0; num_layers = '0;
    start = 1'b0; abort = 1'b0; w_hs = 1'b0; o_last_hs = 1'b0;
    d0 = mk(3, 3, 15, 8, 7, 9);
    da = mk(2, 100, 200, 1, 2, 3);
    db = mk(4, 511, 17, 31, 30, 29);
    dc = mk(0, 5, 6, 7, 8, 10);
    #2;
    chk("reset_state", state_dbg, S_IDLE);
    chk("reset_ctl", {matw, run, last, busy, done}, 5'b0);
    chk("reset_layer", cur_layer, 0);
    chk("reset_fields", fld, 0);
    step();
    reset = 1'b0;

    // start with abort in IDLE: abort wins
    num_layers = '0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", state_dbg, S_IDLE);
    chk("start_abort_busy", busy, 1'b0);

    // single layer, wcnt=3
    write_desc(0, d0);
    start_seq(0);
    run_layer(0, d0, 43'd0, 1'b1, 1'b0, 1'b0);

    // three layers, last with wcnt=0
    write_desc(0, da);
    write_desc(1, db);
    write_desc(2, dc);
    start_seq(2);
    run_layer(0, da, d0, 1'b0, 1'b0, 1'b0);
    run_layer(1, db, da, 1'b0, 1'b0, 1'b0);
    run_layer(2, dc, db, 1'b1, 1'b0, 1'b0);

    // abort in layer 1 MATW after two beats
    start_seq(2);
    run_layer(0, da, dc, 1'b0, 1'b0, 1'b0);
    chk("ab_load", state_dbg, S_LOAD);
    step();
    for (int b = 0; b < 2; b++) begin
      w_hs = 1'b1;
      step();
      w_hs = 1'b0;
    end
    chk("ab_still_matw", matw, 1'b1);
    abort = 1'b1;
    chk("ab_no_done", done, 1'b0);
    step();
    abort = 1'b0;
    chk("ab_idle", state_dbg, S_IDLE);
    chk("ab_ctl", {matw, run, last, busy, done}, 5'b0);
    chk("ab_fields_hold", fld, db[32:0]);
    start_seq(2);
    run_layer(0, da, db, 1'b0, 1'b0, 1'b0);
    run_layer(1, db, da, 1'b0, 1'b0, 1'b0);
    run_layer(2, dc, db, 1'b1, 1'b0, 1'b0);

    // cfg_we/start/stray handshakes while busy are ignored
    start_seq(1);
    run_layer(0, da, dc, 1'b0, 1'b1, 1'b0);
    run_layer(1, db, da, 1'b1, 1'b1, 1'b0);
    start_seq(1);
    run_layer(0, da, db, 1'b0, 1'b0, 1'b0);
    run_layer(1, db, da, 1'b1, 1'b0, 1'b0);

    // asynchronous reset during RUN, descriptors retained
    start_seq(0);
    run_layer(0, da, db, 1'b1, 1'b0, 1'b1);
    step();
    chk("post_rst_idle", state_dbg, S_IDLE);
    start_seq(0);
    run_layer(0, da, 43'd0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
